// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce arbiter: FSM encoding and default sizing.
package debounce_pkg;

    // Arbiter states: IDLE waits for a request, TIMING owns the shared counter.
    typedef enum logic {
        IDLE   = 1'b0,
        TIMING = 1'b1
    } state_e;

    localparam int DEFAULT_N         = 4;
    localparam int DEFAULT_DB_CYCLES = 20;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic stage1_q;
    logic stage2_q;

    // Back-to-back flops give the first stage a full cycle to resolve metastability.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1_q <= 1'b0;
            stage2_q <= 1'b0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/debounce_arbiter.sv
// Debouncer for N buttons sharing one stability timer, handed out round-robin.
module debounce_arbiter
    import debounce_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int CW        = $clog2(DB_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         raw_in,
    output logic [N-1:0]         db_out,
    output logic [N-1:0]         p_edge,
    output logic [N-1:0]         n_edge,
    output logic                 busy,
    output logic [$clog2(N)-1:0] active_idx
);

    localparam int            IW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW:0]   N_WIDE   = (IW + 1)'(N);

    logic [N-1:0]  syncLvl;
    logic [N-1:0]  req;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] rrPtr_q, rrPtr_d;
    logic [N-1:0]  db_q, db_d;
    logic [N-1:0]  pEdge_q, pEdge_d;
    logic [N-1:0]  nEdge_q, nEdge_d;
    logic          grantValid;
    logic [IW-1:0] grantIdx;
    logic [IW:0]   cand;
    logic [IW-1:0] nextPtr;

    for (genvar i = 0; i < N; i++) begin : g_sync
        sync_2ff u_sync (
            .clk   (clk),
            .reset (reset),
            .d_i   (raw_in[i]),
            .q_o   (syncLvl[i])
        );
    end

    // A channel wants the timer whenever its synchronized level disagrees with its debounced level.
    assign req = syncLvl ^ db_q;

    // Round-robin pick: scan from rrPtr_q upward, wrapping at N, and take the first requester.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rrPtr_q} + (IW + 1)'(k);
            if (cand >= N_WIDE) begin
                cand = cand - N_WIDE;
            end
            if (!grantValid && req[cand[IW-1:0]]) begin
                grantValid = 1'b1;
                grantIdx   = cand[IW-1:0];
            end
        end
    end

    assign nextPtr = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);

    // Timer FSM: grant, count stable cycles for the owner, then accept or abandon the change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rrPtr_d = rrPtr_q;
        db_d    = db_q;
        pEdge_d = '0;
        nEdge_d = '0;
        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    state_d = TIMING;
                    cnt_d   = '0;
                    idx_d   = grantIdx;
                end
            end
            TIMING: begin
                if (!req[idx_q]) begin
                    state_d = IDLE;
                    rrPtr_d = nextPtr;
                end else if (cnt_q == CNT_LAST) begin
                    db_d[idx_q] = ~db_q[idx_q];
                    if (db_q[idx_q]) begin
                        nEdge_d[idx_q] = 1'b1;
                    end else begin
                        pEdge_d[idx_q] = 1'b1;
                    end
                    rrPtr_d = nextPtr;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and output registers; reset drops any grant in flight without a pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rrPtr_q <= '0;
            db_q    <= '0;
            pEdge_q <= '0;
            nEdge_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rrPtr_q <= rrPtr_d;
            db_q    <= db_d;
            pEdge_q <= pEdge_d;
            nEdge_q <= nEdge_d;
        end
    end

    assign db_out     = db_q;
    assign p_edge     = pEdge_q;
    assign n_edge     = nEdge_q;
    assign busy       = (state_q == TIMING);
    assign active_idx = (state_q == TIMING) ? idx_q : '0;

endmodule

// File: tb/tb_debounce_arbiter.sv
// Bench for debounce_arbiter: directed scenarios with literal expectations plus random bouncing
// inputs compared every cycle against a behavioural model of the debounce rules.
module tb_debounce_arbiter;

    localparam int N  = 4;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] raw_in;
    logic [N-1:0] db_out;
    logic [N-1:0] p_edge;
    logic [N-1:0] n_edge;
    logic         busy;
    logic [1:0]   active_idx;

    int checks = 0;
    int errors = 0;

    // Behavioural model: synchronizer pipeline, debounced levels, pulses, and timer ownership.
    logic [N-1:0] mSync1 = '0;
    logic [N-1:0] mSync2 = '0;
    logic [N-1:0] mDb    = '0;
    logic [N-1:0] mPe    = '0;
    logic [N-1:0] mNe    = '0;
    bit           mBusy  = 1'b0;
    int           mIdx   = 0;
    int           mRr    = 0;
    int           mStable = 0;

    debounce_arbiter #(.N(N), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .db_out     (db_out),
        .p_edge     (p_edge),
        .n_edge     (n_edge),
        .busy       (busy),
        .active_idx (active_idx)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic modelClear();
        mSync1  = '0;
        mSync2  = '0;
        mDb     = '0;
        mPe     = '0;
        mNe     = '0;
        mBusy   = 1'b0;
        mIdx    = 0;
        mRr     = 0;
        mStable = 0;
    endtask

    // One clock of the debounce rules, using pre-edge synchronized levels.
    task automatic modelStep();
        logic [N-1:0] pe;
        logic [N-1:0] ne;
        int c;
        pe = '0;
        ne = '0;
        if (mBusy) begin
            if (mSync2[mIdx] == mDb[mIdx]) begin
                mBusy = 1'b0;
                mRr   = (mIdx + 1) % N;
            end else begin
                mStable++;
                if (mStable == DB) begin
                    mDb[mIdx] = ~mDb[mIdx];
                    if (mDb[mIdx]) pe[mIdx] = 1'b1;
                    else           ne[mIdx] = 1'b1;
                    mBusy = 1'b0;
                    mRr   = (mIdx + 1) % N;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (mRr + k) % N;
                if (!mBusy && (mSync2[c] != mDb[c])) begin
                    mBusy   = 1'b1;
                    mIdx    = c;
                    mStable = 0;
                end
            end
        end
        mPe    = pe;
        mNe    = ne;
        mSync2 = mSync1;
        mSync1 = raw_in;
    endtask

    // Model advances on every active edge and clears asynchronously with reset.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) modelClear();
            else       modelStep();
        end
    end

    // Every falling edge the DUT outputs must match the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("cmp_db_out", 32'(db_out), 32'(mDb));
            checkOutput("cmp_p_edge", 32'(p_edge), 32'(mPe));
            checkOutput("cmp_n_edge", 32'(n_edge), 32'(mNe));
            checkOutput("cmp_busy", 32'(busy), 32'(mBusy));
            checkOutput("cmp_active_idx", 32'(active_idx), mBusy ? 32'(mIdx) : 32'h0);
            checkOutput("cmp_edge_onehot", 32'($countones(p_edge | n_edge) <= 1), 32'h1);
        end
    end

    task automatic waitEdge(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] v);
        raw_in = v;
    endtask

    task automatic doReset();
        reset  = 1'b1;
        raw_in = '0;
        #1;
        checkOutput("rst_db_out", 32'(db_out), 32'h0);
        checkOutput("rst_p_edge", 32'(p_edge), 32'h0);
        checkOutput("rst_n_edge", 32'(n_edge), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_active_idx", 32'(active_idx), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        waitEdge(1);
    endtask

    // Safety net so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        raw_in = '0;
        reset  = 1'b0;
        #1;

        // Clean press on channel 0.
        doReset();
        applyStimulus(4'b0001);
        waitEdge(6);
        checkOutput("A_db_e6", 32'(db_out), 32'h0);
        checkOutput("A_busy_e6", 32'(busy), 32'h1);
        checkOutput("A_idx_e6", 32'(active_idx), 32'h0);
        waitEdge(1);
        checkOutput("A_db_e7", 32'(db_out), 32'h1);
        checkOutput("A_pedge_e7", 32'(p_edge), 32'h1);
        checkOutput("A_busy_e7", 32'(busy), 32'h0);
        checkOutput("A_model_db_e7", 32'(mDb), 32'h1);
        waitEdge(1);
        checkOutput("A_pedge_e8", 32'(p_edge), 32'h0);

        // Pointer sits at 1: channel 3 is served before channel 0.
        applyStimulus(4'b1000);
        waitEdge(3);
        checkOutput("B_idx_e3", 32'(active_idx), 32'h3);
        checkOutput("B_busy_e3", 32'(busy), 32'h1);
        waitEdge(4);
        checkOutput("B_db_e7", 32'(db_out), 32'h9);
        checkOutput("B_pedge_e7", 32'(p_edge), 32'h8);
        waitEdge(1);
        checkOutput("B_idx_e8", 32'(active_idx), 32'h0);
        checkOutput("B_pedge_e8", 32'(p_edge), 32'h0);
        waitEdge(4);
        checkOutput("B_db_e12", 32'(db_out), 32'h8);
        checkOutput("B_nedge_e12", 32'(n_edge), 32'h1);

        // Release of channel 3.
        applyStimulus(4'b0000);
        waitEdge(6);
        checkOutput("C_db_e6", 32'(db_out), 32'h8);
        waitEdge(1);
        checkOutput("C_db_e7", 32'(db_out), 32'h0);
        checkOutput("C_nedge_e7", 32'(n_edge), 32'h8);
        waitEdge(1);
        checkOutput("C_nedge_e8", 32'(n_edge), 32'h0);

        // Channel 1 bounces: high for three cycles only.
        applyStimulus(4'b0010);
        waitEdge(3);
        checkOutput("D_busy_e3", 32'(busy), 32'h1);
        checkOutput("D_idx_e3", 32'(active_idx), 32'h1);
        applyStimulus(4'b0000);
        waitEdge(3);
        checkOutput("D_busy_e6", 32'(busy), 32'h0);
        checkOutput("D_db_e6", 32'(db_out), 32'h0);
        waitEdge(1);
        checkOutput("D_db_e7", 32'(db_out), 32'h0);
        checkOutput("D_pedge_e7", 32'(p_edge), 32'h0);
        waitEdge(2);
        // Pointer should now be 2, so channel 3 beats channel 1.
        applyStimulus(4'b1010);
        waitEdge(3);
        checkOutput("D_rr_idx", 32'(active_idx), 32'h3);
        waitEdge(12);
        checkOutput("D_db_settled", 32'(db_out), 32'hA);

        // Channels 0 and 2 rise together.
        doReset();
        applyStimulus(4'b0101);
        waitEdge(7);
        checkOutput("E_db_e7", 32'(db_out), 32'h1);
        checkOutput("E_pedge_e7", 32'(p_edge), 32'h1);
        waitEdge(1);
        checkOutput("E_busy_e8", 32'(busy), 32'h1);
        checkOutput("E_idx_e8", 32'(active_idx), 32'h2);
        waitEdge(3);
        checkOutput("E_db_e11", 32'(db_out), 32'h1);
        waitEdge(1);
        checkOutput("E_db_e12", 32'(db_out), 32'h5);
        checkOutput("E_pedge_e12", 32'(p_edge), 32'h4);

        // Reset in the middle of timing channel 1, then re-debounce everything held high.
        applyStimulus(4'b0111);
        waitEdge(5);
        checkOutput("F_busy_pre", 32'(busy), 32'h1);
        checkOutput("F_idx_pre", 32'(active_idx), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("F_db_rst", 32'(db_out), 32'h0);
        checkOutput("F_pedge_rst", 32'(p_edge), 32'h0);
        checkOutput("F_nedge_rst", 32'(n_edge), 32'h0);
        checkOutput("F_busy_rst", 32'(busy), 32'h0);
        checkOutput("F_idx_rst", 32'(active_idx), 32'h0);
        checkOutput("F_model_busy_rst", 32'(mBusy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        waitEdge(6);
        checkOutput("F_db_e6", 32'(db_out), 32'h0);
        waitEdge(1);
        checkOutput("F_db_e7", 32'(db_out), 32'h1);
        checkOutput("F_pedge_e7", 32'(p_edge), 32'h1);
        waitEdge(5);
        checkOutput("F_db_e12", 32'(db_out), 32'h3);
        waitEdge(5);
        checkOutput("F_db_e17", 32'(db_out), 32'h7);

        // Random bouncing on all channels with occasional resets.
        doReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(11) == 0) raw_in[b] = ~raw_in[b];
            end
            if ($urandom_range(799) == 0) begin
                #2;
                reset = 1'b1;
                @(negedge clk);
                #2;
                reset = 1'b0;
            end
        end
        applyStimulus(4'b0000);
        waitEdge(40);
        checkOutput("G_final_db", 32'(db_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
